// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package reg_file_sb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: issue handshake, writeback clear, flush and sticky wb_err.
// Honours REG_FILE_SB_BYPASS_EN: read-port busy then shows the post-edge value.
module reg_file_sb_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic                 wb0_en,
  input  logic [AW-1:0]        wb0_addr,
  input  logic                 wb1_en,
  input  logic [AW-1:0]        wb1_addr,
  input  logic                 flush,
  output logic                 wb_err
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wb_hit_iss;
  logic                iss_fire;
  logic                wb_err_d;

  // A writeback landing on the destination this cycle frees it, so a
  // re-issue may proceed in the same cycle.
  assign wb_hit_iss = (wb0_en && (wb0_addr == iss_addr)) ||
                      (wb1_en && (wb1_addr == iss_addr));
  assign iss_ready  = !flush && !(busy_q[iss_addr] && !wb_hit_iss);
  assign iss_fire   = iss_valid && iss_ready && (iss_addr != '0);

  // Writebacks to registers already idle indicate a lost or duplicated
  // completion; a flush legitimately orphans in-flight results.
  assign wb_err_d = !flush &&
                    ((wb0_en && (wb0_addr != '0) && !busy_q[wb0_addr]) ||
                     (wb1_en && (wb1_addr != '0) && !busy_q[wb1_addr]));

  // NOTE: blocking assignments in always_comb, default first; the statement
  // order is the priority (clear, then new issue wins, then flush overrides).
  always_comb begin
    busy_d = busy_q;
    if (wb0_en) busy_d[wb0_addr] = 1'b0;
    if (wb1_en) busy_d[wb1_addr] = 1'b0;
    if (iss_fire) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      wb_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (wb_err_d) wb_err <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
`ifdef REG_FILE_SB_BYPASS_EN
      rd_busy[k] = busy_d[rd_addr[k*AW +: AW]];
`else
      rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
`endif
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two writeback ports, combinational reads and a busy scoreboard.
// Optional REG_FILE_SB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ready,
  input  logic                     wb0_en,
  input  logic [AW-1:0]            wb0_addr,
  input  logic [DATA_W-1:0]        wb0_data,
  input  logic                     wb1_en,
  input  logic [AW-1:0]            wb1_addr,
  input  logic [DATA_W-1:0]        wb1_data,
  input  logic                     flush,
  output logic                     wb_err
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  reg_file_sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb0_en    (wb0_en),
    .wb0_addr  (wb0_addr),
    .wb1_en    (wb1_en),
    .wb1_addr  (wb1_addr),
    .flush     (flush),
    .wb_err    (wb_err)
  );

  // NOTE: the array is reset because the architecture requires every register
  // to read zero after reset; this prevents mapping it onto RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // wb1 is assigned last so it wins a same-address collision.
      if (wb0_en && (wb0_addr != '0)) regs[wb0_addr] <= wb0_data;
      if (wb1_en && (wb1_addr != '0)) regs[wb1_addr] <= wb1_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*AW +: AW] == '0) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
`ifdef REG_FILE_SB_BYPASS_EN
      end else if (wb1_en && (wb1_addr == rd_addr[k*AW +: AW])) begin
        rd_data[k*DATA_W +: DATA_W] = wb1_data;
      end else if (wb0_en && (wb0_addr == rd_addr[k*AW +: AW])) begin
        rd_data[k*DATA_W +: DATA_W] = wb0_data;
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              iss_ready;
  logic              wb0_en, wb1_en;
  logic [AW-1:0]     wb0_addr, wb1_addr;
  logic [DW-1:0]     wb0_data, wb1_data;
  logic              flush;
  logic              wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb0_en    (wb0_en),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb1_en    (wb1_en),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .flush     (flush),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    iss_valid = 1'b0; iss_addr = '0;
    wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd(AW'(i), AW'(NR - 1 - i));
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL reset_rd_data addr %0d/%0d: got %h expected 0", i, NR - 1 - i, rd_data);
      end
      n_checks++;
      if (rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_rd_busy addr %0d/%0d: got %b expected 00", i, NR - 1 - i, rd_busy);
      end
    end
    n_checks++;
    if (wb_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_wb_err: got %b expected 0", wb_err);
    end
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_iss_ready: got %b expected 1", iss_ready);
    end
  endtask

  task automatic test_issue_wb();
    iss_valid = 1'b1; iss_addr = 5'd5;
    rd(5'd5, 5'd0);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue5_ready: got %b expected 1", iss_ready);
    end
    tick();
    rd(5'd5, 5'd0);
    n_checks++;
    if (iss_ready !== 1'b0) begin
      n_fail++; $display("FAIL issue5_blocked: got %b expected 0", iss_ready);
    end
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy5_set: got %b expected 1", rd_busy[0]);
    end
    tick();
    iss_valid = 1'b0;
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    rd(5'd5, 5'd0);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL wb5_frees_ready: got %b expected 1", iss_ready);
    end
`ifdef REG_FILE_SB_BYPASS_EN
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL wb5_bypass: got %h/%b expected deadbeef/0", rd_data[DW-1:0], rd_busy[0]);
    end
`else
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h0 || rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL wb5_no_bypass: got %h/%b expected 0/1", rd_data[DW-1:0], rd_busy[0]);
    end
`endif
    tick();
    idle();
    rd(5'd5, 5'd0);
    n_checks++;
    if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wb5_data: got %h expected deadbeef", rd_data[DW-1:0]);
    end
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL wb5_busy_clear: got %b expected 0", rd_busy[0]);
    end
    n_checks++;
    if (wb_err !== 1'b0) begin
      n_fail++; $display("FAIL wb5_no_err: got %b expected 0", wb_err);
    end
  endtask

  task automatic test_dual_wb();
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h11;
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h22;
    tick();
    idle();
    rd(5'd7, 5'd5);
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h22) begin
      n_fail++; $display("FAIL dual_wb_data: got %h expected 22", rd_data[DW-1:0]);
    end
    n_checks++;
    if (rd_data[2*DW-1:DW] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL dual_wb_other_reg: got %h expected deadbeef", rd_data[2*DW-1:DW]);
    end
    n_checks++;
    if (wb_err !== 1'b1) begin
      n_fail++; $display("FAIL dual_wb_err: got %b expected 1", wb_err);
    end
  endtask

  task automatic test_issue_wb_same();
    iss_valid = 1'b1; iss_addr = 5'd3;
    wb1_en = 1'b1; wb1_addr = 5'd3; wb1_data = 32'h55;
    rd(5'd3, 5'd0);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL iss_wb3_ready: got %b expected 1", iss_ready);
    end
`ifdef REG_FILE_SB_BYPASS_EN
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL iss_wb3_busy_bypass: got %b expected 1", rd_busy[0]);
    end
`else
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL iss_wb3_busy_pre: got %b expected 0", rd_busy[0]);
    end
`endif
    tick();
    idle();
    rd(5'd3, 5'd0);
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h55) begin
      n_fail++; $display("FAIL iss_wb3_data: got %h expected 55", rd_data[DW-1:0]);
    end
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL iss_wb3_busy: got %b expected 1", rd_busy[0]);
    end
  endtask

  task automatic test_flush();
    iss_valid = 1'b1;
    iss_addr = 5'd1; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd4; tick();
    idle();
    rd(5'd1, 5'd2);
    n_checks++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL pre_flush_busy_1_2: got %b expected 11", rd_busy);
    end
    rd(5'd4, 5'd3);
    n_checks++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL pre_flush_busy_4_3: got %b expected 11", rd_busy);
    end
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    n_checks++;
    if (iss_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_iss_ready: got %b expected 0", iss_ready);
    end
    tick();
    idle();
    rd(5'd1, 5'd2);
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_busy_1_2: got %b expected 00", rd_busy);
    end
    rd(5'd4, 5'd9);
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_busy_4_9: got %b expected 00", rd_busy);
    end
    rd(5'd3, 5'd7);
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_busy_3_7: got %b expected 00", rd_busy);
    end
    n_checks++;
    if (rd_data !== {32'h22, 32'h55}) begin
      n_fail++; $display("FAIL flush_data_kept: got %h expected 0000002200000055", rd_data);
    end
  endtask

  task automatic test_reg0();
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFFFFFF;
    wb1_en = 1'b1; wb1_addr = 5'd0; wb1_data = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    rd(5'd0, 5'd0);
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL reg0_iss_ready: got %b expected 1", iss_ready);
    end
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL reg0_rd_same_cycle: got %h expected 0", rd_data);
    end
    tick();
    idle();
    rd(5'd0, 5'd0);
    n_checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reg0_after: got %h/%b expected 0/00", rd_data, rd_busy);
    end
    n_checks++;
    if (wb_err !== 1'b1) begin
      n_fail++; $display("FAIL reg0_wb_err_unchanged: got %b expected 1", wb_err);
    end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_addr = 5'd10;
    wb0_en = 1'b1; wb0_addr = 5'd11; wb0_data = 32'hAB;
    rd(5'd5, 5'd3);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL async_reset_data: got %h expected 0", rd_data);
    end
    n_checks++;
    if (wb_err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_wb_err: got %b expected 0", wb_err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    rd(5'd10, 5'd11);
    n_checks++;
    if (rd_busy !== 2'b00 || rd_data !== '0) begin
      n_fail++; $display("FAIL reset_discard: got %h/%b expected 0/00", rd_data, rd_busy);
    end
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick();
    idle();
    rd(5'd10, 5'd0);
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_issue: got %b expected 1", rd_busy[0]);
    end
    wb0_en = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h77;
    tick();
    idle();
    rd(5'd10, 5'd0);
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h77 || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_wb: got %h/%b expected 77/0", rd_data[DW-1:0], rd_busy[0]);
    end
    n_checks++;
    if (wb_err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_wb_err: got %b expected 0", wb_err);
    end
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_dual_wb();
    test_issue_wb_same();
    test_flush();
    test_reg0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
